arbitro_multiplicador: RTL
==========================

Name: arbitro_multiplicador

Overview:
Round-robin arbiter and sequencer that shares one combinational saturating signed fixed-point multiplier (Q8.16, 25-bit) among 4 requesters. It latches the winning requester's operands onto the shared multiplier's inputs and captures the multiplier output one cycle later. It returns the product with a one-cycle acknowledge pulse and flags saturated results. It sits between the arithmetic clients (filter/controller stages) and the single multiplier instance.

Parameters:
largo, 24, MSB index of operands/result (word width largo+1 = 25 bits, two's complement Q8.16)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  4  level request per requester; held until ack
op_a  in  4*(largo+1)  packed operand A; requester i at bits [i*(largo+1) +: largo+1]
op_b  in  4*(largo+1)  packed operand B, same packing
mult_a  out  largo+1  registered operand A to the shared multiplier
mult_b  out  largo+1  registered operand B to the shared multiplier
mult_y  in  largo+1  combinational saturated product from the shared multiplier
ack  out  4  one-hot, one-cycle pulse: result valid for requester i
resultado  out  largo+1  registered product, valid while ack != 0, held otherwise
sat  out  1  registered; 1 when the captured resultado equals 0_111..1 or 1_000..0
ocupado  out  1  1 whenever state != IDLE

Behaviour:
- Reset (async, immediate): state=IDLE, ptr=0, idx=0, mult_a=mult_b=0, resultado=0, sat=0, ack=0. Reset mid-operation aborts it; no ack is issued.
- FSM states: IDLE, CARGA, RESPUESTA.
- IDLE: if req!=0, grant the first asserted req scanning ptr, ptr+1, ... mod 4. At the clock edge: idx<=grant, mult_a/mult_b<=op_a/op_b slice of grant, ptr<=(grant+1) mod 4, go to CARGA. If req==0, stay; mult_a/mult_b hold their values.
- CARGA (1 cycle): the multiplier settles. At the edge: resultado<=mult_y, sat<=(mult_y=={0,1..1} || mult_y=={1,0..0}), ack<=onehot(idx), go to RESPUESTA.
- RESPUESTA (1 cycle): ack is high. At the edge: ack<=0, go to IDLE unconditionally.
- The requester samples ack and deasserts req by the next edge. A req still high on return to IDLE is treated as a new request.
- Latency: req sampled high in IDLE at cycle 0, ack high in cycle 2. Throughput is one product per 3 cycles.
- Operands are sampled only at the grant edge. Later changes to op_a/op_b or req of the granted requester do not affect the operation in progress.
- If the granted requester drops req before ack, the operation still completes and ack is still pulsed.
- Fairness: with all 4 req held high, grants go to 0,1,2,3,0,... Any held req is acked within 12 cycles.
- Simultaneous req changes in the grant cycle: only the values at the edge count.
- No arithmetic is performed in this block. The result is the multiplier's value passed through unmodified; sat only compares it against the two saturation codes.

Test Plan:
- Reset then req=0001, op_a0=0x0018000 (1.5), op_b0=0x0020000 (2.0) -> ack=0001 in cycle 2, resultado=0x0030000, sat=0, ocupado high cycles 1-2.
- req=0010, a=0x1FE0000 (-2.0), b=0x0030000 (3.0) -> resultado=0x1FA0000 (-6.0), sat=0, ack=0010.
- req=0100, a=b=0x0640000 (100.0) -> resultado=0x0FFFFFF, sat=1; a=0x19C0000 (-100.0), b=0x0640000 -> resultado=0x1000000, sat=1.
- req=1111 held continuously -> ack sequence 0001,0010,0100,1000,0001 at cycles 2,5,8,11,14. After releasing req0 only, the next grant goes to 1.
- Grant requester 2, then change op_a2 and drop req2 in the CARGA cycle -> ack=0100 still pulses, with resultado computed from the originally latched operands.
- Assert reset during CARGA -> ack stays 0, all outputs 0, state IDLE. After release with req=1000, the grant goes to 3 with ptr restarted at 0.

Source files
------------

// File: rtl/arbitro_multiplicador.sv
// Round-robin arbiter that time-shares one external saturating Q8.16 multiplier among four requesters.
// Operands are latched at grant, the product is captured one cycle later and returned with a one-hot ack pulse.
module arbitro_multiplicador #(
   parameter int largo = 24
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [3:0]               req,
   input  logic [4*(largo+1)-1:0]   op_a,
   input  logic [4*(largo+1)-1:0]   op_b,
   output logic [largo:0]           mult_a,
   output logic [largo:0]           mult_b,
   input  logic [largo:0]           mult_y,
   output logic [3:0]               ack,
   output logic [largo:0]           resultado,
   output logic                     sat,
   output logic                     ocupado
);

   typedef enum logic [1:0] {IDLE, CARGA, RESPUESTA} estado_t;

   estado_t    state;
   estado_t    state_next;
   logic [1:0] ptr;
   logic [1:0] idx;
   logic [1:0] grant;
   logic       hay_req;

   function automatic logic es_saturado(input logic [largo:0] y);
      return (y == {1'b0, {largo{1'b1}}}) || (y == {1'b1, {largo{1'b0}}});
   endfunction

   // First asserted request found scanning upward from ptr, wrapping mod 4.
   always_comb begin
      grant   = ptr;
      hay_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (!hay_req && req[ptr + 2'(k)]) begin
            grant   = ptr + 2'(k);
            hay_req = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (hay_req) state_next = CARGA;
         CARGA:     state_next = RESPUESTA;
         RESPUESTA: state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr       <= '0;
         idx       <= '0;
         mult_a    <= '0;
         mult_b    <= '0;
         resultado <= '0;
         sat       <= 1'b0;
         ack       <= '0;
      end else begin
         ack <= '0;
         case (state)
            IDLE: begin
               if (hay_req) begin
                  idx    <= grant;
                  ptr    <= grant + 2'd1;
                  mult_a <= op_a[grant*(largo+1) +: largo+1];
                  mult_b <= op_b[grant*(largo+1) +: largo+1];
               end
            end
            // Multiplier has settled on the latched operands during this cycle.
            CARGA: begin
               resultado <= mult_y;
               sat       <= es_saturado(mult_y);
               ack       <= 4'b0001 << idx;
            end
            default: ;
         endcase
      end
   end

   assign ocupado = (state != IDLE);

endmodule
